// File: rtl/voice_allocator.sv
// Voice allocator feeding a bank of ADSR envelopes: maps note-on/off events to voices,
// preferring free voices, then releasing ones, then stealing the oldest held voice.
module voice_allocator #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 7,
  parameter int AGE_W  = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       EventValid,
  output logic                       EventReady,
  input  logic                       EventOn,
  input  logic [NOTE_W-1:0]          EventNote,
  input  logic [VOICES-1:0]          Running,
  output logic [VOICES-1:0]          Gate,
  output logic [VOICES*NOTE_W-1:0]   VoiceNote,
  output logic                       Steal
);

  localparam int TW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, GAP, ASSIGN} state_t;

  state_t              state_q, state_d;
  logic                on_q, on_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [TW-1:0]       target_q, target_d;
  logic [VOICES-1:0]   gate_q, gate_d;
  logic [NOTE_W-1:0]   vnote_q [VOICES];
  logic [NOTE_W-1:0]   vnote_d [VOICES];
  logic [AGE_W-1:0]    age_q   [VOICES];
  logic [AGE_W-1:0]    age_d   [VOICES];
  logic                steal_q, steal_d;
  logic                accept;

  logic                match_hit, free_hit, rel_hit, old_hit;
  logic [TW-1:0]       match_idx, free_idx, rel_idx, old_idx;
  logic [AGE_W-1:0]    old_age;
  logic [VOICES-1:0]   match_vec;

  // Voice classification; first hit in index order wins ties, strict '>' keeps lowest index among equal ages.
  always_comb begin
    match_hit = 1'b0;
    free_hit  = 1'b0;
    rel_hit   = 1'b0;
    old_hit   = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    rel_idx   = '0;
    old_idx   = '0;
    old_age   = '0;
    match_vec = '0;
    for (int i = 0; i < VOICES; i++) begin
      match_vec[i] = gate_q[i] && (vnote_q[i] == note_q);
      if (match_vec[i] && !match_hit) begin
        match_hit = 1'b1;
        match_idx = TW'(i);
      end
      if (!gate_q[i] && !Running[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = TW'(i);
      end
      if (!gate_q[i] && Running[i] && !rel_hit) begin
        rel_hit = 1'b1;
        rel_idx = TW'(i);
      end
      if (gate_q[i] && (!old_hit || (age_q[i] > old_age))) begin
        old_hit = 1'b1;
        old_idx = TW'(i);
        old_age = age_q[i];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN: begin
        if (!on_q)                    state_d = IDLE;
        else if (match_hit)           state_d = GAP;
        else if (free_hit || rel_hit) state_d = ASSIGN;
        else                          state_d = GAP;
      end
      GAP:     state_d = ASSIGN;
      ASSIGN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    EventReady = (state_q == IDLE);
    accept     = EventValid && EventReady;
  end

  always_comb begin
    on_d     = on_q;
    note_d   = note_q;
    target_d = target_q;
    gate_d   = gate_q;
    vnote_d  = vnote_q;
    age_d    = age_q;
    steal_d  = 1'b0;
    if (accept) begin
      on_d   = EventOn;
      note_d = EventNote;
    end
    case (state_q)
      SCAN: begin
        if (!on_q) begin
          gate_d = gate_q & ~match_vec;
        end else if (match_hit) begin
          target_d = match_idx;
        end else if (free_hit) begin
          target_d = free_idx;
        end else if (rel_hit) begin
          target_d = rel_idx;
        end else begin
          target_d = old_idx;
          steal_d  = 1'b1;
        end
      end
      // Forced low cycle so the envelope sees a falling gate before retrigger.
      GAP: begin
        for (int i = 0; i < VOICES; i++) begin
          if (TW'(i) == target_q) gate_d[i] = 1'b0;
        end
      end
      ASSIGN: begin
        for (int i = 0; i < VOICES; i++) begin
          if (TW'(i) == target_q) begin
            vnote_d[i] = note_q;
            gate_d[i]  = 1'b1;
            age_d[i]   = '0;
          end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      on_q     <= 1'b0;
      note_q   <= '0;
      target_q <= '0;
      gate_q   <= '0;
      steal_q  <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        vnote_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      on_q     <= on_d;
      note_q   <= note_d;
      target_q <= target_d;
      gate_q   <= gate_d;
      steal_q  <= steal_d;
      vnote_q  <= vnote_d;
      age_q    <= age_d;
    end
  end

  assign Gate  = gate_q;
  assign Steal = steal_q;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_note
    assign VoiceNote[gi*NOTE_W +: NOTE_W] = vnote_q[gi];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (VOICES=4, NOTE_W=7, AGE_W=4); one task per scenario.
module tb_voice_allocator;

  logic        Clock;
  logic        Reset;
  logic        EventValid;
  logic        EventReady;
  logic        EventOn;
  logic [6:0]  EventNote;
  logic [3:0]  Running;
  logic [3:0]  Gate;
  logic [27:0] VoiceNote;
  logic        Steal;

  int total = 0;
  int bad   = 0;

  voice_allocator #(.VOICES(4), .NOTE_W(7), .AGE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .EventValid(EventValid), .EventReady(EventReady),
    .EventOn(EventOn), .EventNote(EventNote), .Running(Running), .Gate(Gate),
    .VoiceNote(VoiceNote), .Steal(Steal)
  );

  always #5 Clock = ~Clock;

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic on, input logic [6:0] note);
    int n;
    n = 0;
    while (EventReady !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (EventReady !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: EventReady=%b required 1", EventReady);
    end
    $display("event on=%0d note=%0d t=%0t", on, note, $time);
    EventValid = 1'b1;
    EventOn    = on;
    EventNote  = note;
    @(posedge Clock);
    @(negedge Clock);
    EventValid = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (EventReady !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (EventReady !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL settle_timeout: EventReady=%b required 1", EventReady);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Running = 4'b0000;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic fill_four();
    send(1'b1, 7'd60); settle();
    send(1'b1, 7'd62); settle();
    send(1'b1, 7'd64); settle();
    send(1'b1, 7'd65); settle();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0000 || Steal !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: Gate=%b Steal=%b required 0000 0", Gate, Steal);
    end
    total++;
    if (VoiceNote !== 28'd0) begin
      bad++;
      $display("FAIL reset_voicenote: got %h required 0", VoiceNote);
    end
    Reset = 1'b1;
    @(negedge Clock);
    total++;
    if (EventReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b required 1", EventReady);
    end
  endtask

  task automatic test_first_note();
    do_reset();
    send(1'b1, 7'd60);
    total++;
    if (EventReady !== 1'b0 || Gate !== 4'b0000) begin
      bad++;
      $display("FAIL first_k: Ready=%b Gate=%b required 0 0000", EventReady, Gate);
    end
    @(negedge Clock);
    total++;
    if (EventReady !== 1'b0 || Gate !== 4'b0000) begin
      bad++;
      $display("FAIL first_k1: Ready=%b Gate=%b required 0 0000", EventReady, Gate);
    end
    @(negedge Clock);
    total++;
    if (EventReady !== 1'b1 || Gate !== 4'b0001 || VoiceNote[6:0] !== 7'd60) begin
      bad++;
      $display("FAIL first_k2: Ready=%b Gate=%b Note0=%0d required 1 0001 60",
               EventReady, Gate, VoiceNote[6:0]);
    end
  endtask

  task automatic test_note_off();
    do_reset();
    send(1'b1, 7'd60); settle();
    send(1'b1, 7'd62); settle();
    send(1'b1, 7'd64); settle();
    total++;
    if (Gate !== 4'b0111 || VoiceNote[20:0] !== {7'd64, 7'd62, 7'd60}) begin
      bad++;
      $display("FAIL three_notes: Gate=%b notes=%h required 0111", Gate, VoiceNote[20:0]);
    end
    send(1'b0, 7'd62);
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0101 || EventReady !== 1'b1) begin
      bad++;
      $display("FAIL off_62: Gate=%b Ready=%b required 0101 1", Gate, EventReady);
    end
    send(1'b0, 7'd65);
    total++;
    if (EventReady !== 1'b0) begin
      bad++;
      $display("FAIL off_65_busy: Ready=%b required 0", EventReady);
    end
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0101 || EventReady !== 1'b1) begin
      bad++;
      $display("FAIL off_65: Gate=%b Ready=%b required 0101 1", Gate, EventReady);
    end
    total++;
    if (VoiceNote[13:7] !== 7'd62) begin
      bad++;
      $display("FAIL off_keeps_pitch: Note1=%0d required 62", VoiceNote[13:7]);
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] exp_gate [4];
    exp_gate = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
    do_reset();
    send(1'b1, 7'd60); settle();
    send(1'b1, 7'd60);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (Gate !== exp_gate[c] || Steal !== 1'b0) begin
        bad++;
        $display("FAIL retrig_c%0d: Gate=%b Steal=%b required %b 0", c, Gate, Steal, exp_gate[c]);
      end
      if (c < 3) @(negedge Clock);
    end
    total++;
    if (EventReady !== 1'b1 || VoiceNote[6:0] !== 7'd60) begin
      bad++;
      $display("FAIL retrig_end: Ready=%b Note0=%0d required 1 60", EventReady, VoiceNote[6:0]);
    end
  endtask

  task automatic test_steal();
    logic [3:0] exp_gate [4];
    logic       exp_steal [4];
    int         pulses;
    exp_gate  = '{4'b1111, 4'b1111, 4'b1110, 4'b1111};
    exp_steal = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    fill_four();
    send(1'b1, 7'd67);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (Steal === 1'b1) pulses++;
      total++;
      if (Gate !== exp_gate[c] || Steal !== exp_steal[c]) begin
        bad++;
        $display("FAIL steal_c%0d: Gate=%b Steal=%b required %b %b",
                 c, Gate, Steal, exp_gate[c], exp_steal[c]);
      end
      if (c < 3) @(negedge Clock);
    end
    total++;
    if (pulses != 1 || VoiceNote[6:0] !== 7'd67 || EventReady !== 1'b1) begin
      bad++;
      $display("FAIL steal_end: pulses=%0d Note0=%0d Ready=%b required 1 67 1",
               pulses, VoiceNote[6:0], EventReady);
    end
    // Ages now v1=3, v2=2, v3=1, v0=0: next steal must take voice1.
    send(1'b1, 7'd69); settle();
    total++;
    if (VoiceNote !== {7'd65, 7'd64, 7'd69, 7'd67} || Gate !== 4'b1111) begin
      bad++;
      $display("FAIL steal_second: notes=%h Gate=%b required v1=69", VoiceNote, Gate);
    end
  endtask

  task automatic test_release_pref();
    do_reset();
    send(1'b1, 7'd60); settle();
    send(1'b1, 7'd62); settle();
    send(1'b1, 7'd64); settle();
    send(1'b0, 7'd62); settle();
    send(1'b0, 7'd64); settle();
    Running = 4'b0010;
    send(1'b1, 7'd70);
    @(negedge Clock);
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0101 || VoiceNote[20:14] !== 7'd70 || EventReady !== 1'b1) begin
      bad++;
      $display("FAIL prefer_free: Gate=%b Note2=%0d Ready=%b required 0101 70 1",
               Gate, VoiceNote[20:14], EventReady);
    end

    do_reset();
    send(1'b1, 7'd60); settle();
    send(1'b1, 7'd62); settle();
    send(1'b1, 7'd64); settle();
    send(1'b0, 7'd62); settle();
    send(1'b0, 7'd64); settle();
    Running = 4'b1110;
    send(1'b1, 7'd70);
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0001) begin
      bad++;
      $display("FAIL releasing_k1: Gate=%b required 0001", Gate);
    end
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0011 || VoiceNote[13:7] !== 7'd70 || EventReady !== 1'b1) begin
      bad++;
      $display("FAIL prefer_releasing: Gate=%b Note1=%0d Ready=%b required 0011 70 1",
               Gate, VoiceNote[13:7], EventReady);
    end
    Running = 4'b0000;
  endtask

  task automatic test_reset_in_gap();
    do_reset();
    fill_four();
    send(1'b1, 7'd67);
    @(negedge Clock);
    total++;
    if (Steal !== 1'b1) begin
      bad++;
      $display("FAIL gap_reached: Steal=%b required 1", Steal);
    end
    Reset = 1'b0;
    #1;
    total++;
    if (Gate !== 4'b0000 || VoiceNote !== 28'd0 || Steal !== 1'b0) begin
      bad++;
      $display("FAIL gap_reset: Gate=%b notes=%h Steal=%b required 0 0 0", Gate, VoiceNote, Steal);
    end
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    total++;
    if (EventReady !== 1'b1 || Steal !== 1'b0 || Gate !== 4'b0000) begin
      bad++;
      $display("FAIL gap_after: Ready=%b Steal=%b Gate=%b required 1 0 0000", EventReady, Steal, Gate);
    end
    send(1'b1, 7'd72);
    @(negedge Clock);
    @(negedge Clock);
    total++;
    if (Gate !== 4'b0001 || VoiceNote[6:0] !== 7'd72 || Steal !== 1'b0) begin
      bad++;
      $display("FAIL gap_next_note: Gate=%b Note0=%0d Steal=%b required 0001 72 0",
               Gate, VoiceNote[6:0], Steal);
    end
  endtask

  initial begin
    Clock      = 1'b0;
    Reset      = 1'b0;
    EventValid = 1'b0;
    EventOn    = 1'b0;
    EventNote  = 7'd0;
    Running    = 4'b0000;
    test_reset();
    test_first_note();
    test_note_off();
    test_retrigger();
    test_steal();
    test_release_pref();
    test_reset_in_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
